// File: rtl/vsmp_core_param_if.sv
// -----------------------------------------------------------------------------
// vsmp_core_param_if
// Bus bundle between a VSMP core and whoever drives it: the run request, the
// program-load port and every observable status/output register of the core.
//   master : drives RUN / PROG_*, observes core status (testbench or host)
//   slave  : the core itself
// Parameters must match the core instance (DW data width, AW address width).
// -----------------------------------------------------------------------------
interface vsmp_core_param_if #(
    parameter int DW = 4,
    parameter int AW = 2
);
    localparam int IW = 32'd4 + DW;

    logic          RUN;        // start/resume request, honoured only in IDLE
    logic          PROG_WE;    // program write strobe, honoured only in IDLE
    logic [AW-1:0] PROG_ADDR;  // program write address
    logic [IW-1:0] PROG_DATA;  // program write word {opcode, operand}
    logic [3:0]    PHASE;      // one-hot phase, 0000 when idle
    logic [AW-1:0] PC;         // program counter
    logic [3:0]    INSTR;      // opcode held in the instruction register
    logic [DW-1:0] ACCA;       // accumulator A
    logic [DW-1:0] ACCB;       // accumulator B
    logic          ZERO;       // zero flag
    logic          CARRY;      // carry (ADD) / borrow (SUB) flag
    logic [DW-1:0] OUT_DATA;   // last value emitted by OUT
    logic          OUT_VALID;  // one-cycle pulse for a new OUT_DATA
    logic          HALTED;     // set by HLT, cleared by an accepted RUN

    modport master (
        output RUN, PROG_WE, PROG_ADDR, PROG_DATA,
        input  PHASE, PC, INSTR, ACCA, ACCB, ZERO, CARRY, OUT_DATA, OUT_VALID, HALTED
    );

    modport slave (
        input  RUN, PROG_WE, PROG_ADDR, PROG_DATA,
        output PHASE, PC, INSTR, ACCA, ACCB, ZERO, CARRY, OUT_DATA, OUT_VALID, HALTED
    );
endinterface

// File: rtl/vsmp_core_param.sv
// -----------------------------------------------------------------------------
// vsmp_core_param
// Parametrised VSMP processor: loadable program memory (2^AW words of 4+DW
// bits), a four-phase control unit, accumulators A/B, ALU, program counter,
// ZERO/CARRY flags, an OUT port and halt/run control.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset (program memory is kept)
//   bus  : vsmp_core_param_if.slave -- RUN, PROG_WE/ADDR/DATA in;
//          PHASE, PC, INSTR, ACCA, ACCB, ZERO, CARRY, OUT_DATA, OUT_VALID,
//          HALTED out (all driven straight from registers)
// Instruction word: opcode = [IW-1:DW], operand K = [DW-1:0], target T = K[AW-1:0].
// -----------------------------------------------------------------------------
module vsmp_core_param #(
    parameter int DW = 4,
    parameter int AW = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    vsmp_core_param_if.slave     bus
);
    localparam int IW    = 32'd4 + DW;
    localparam int DEPTH = 32'd1 << AW;

    // State encoding doubles as the one-hot PHASE output, so PHASE is a register.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'b0000,
        ST_FETCH     = 4'b0001,
        ST_DECODE    = 4'b0010,
        ST_EXECUTE   = 4'b0100,
        ST_WRITEBACK = 4'b1000
    } state_t;

    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_OUT  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_MOVB = 4'h8;
    localparam logic [3:0] OP_HLT  = 4'hF;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [IW-1:0] mem_r [DEPTH];
    logic [IW-1:0] ir_r;
    logic [AW-1:0] pc_r;
    logic [DW-1:0] acca_r;
    logic [DW-1:0] accb_r;
    logic          zero_r;
    logic          carry_r;
    logic [DW-1:0] out_data_r;
    logic          out_valid_r;
    logic          halted_r;

    logic [3:0]    opcode_s;
    logic [DW-1:0] operand_s;
    logic [AW-1:0] target_s;
    logic [AW-1:0] pc_inc_s;
    logic [AW-1:0] pc_nxt_s;
    logic [DW:0]   sum_s;
    logic [DW:0]   diff_s;
    logic [DW-1:0] acca_nxt_s;
    logic [DW-1:0] accb_nxt_s;
    logic          zero_nxt_s;
    logic          carry_nxt_s;
    logic [DW-1:0] out_data_nxt_s;
    logic          out_valid_nxt_s;

    assign opcode_s  = ir_r[IW-1:DW];
    assign operand_s = ir_r[DW-1:0];
    assign target_s  = operand_s[AW-1:0];
    assign pc_inc_s  = pc_r + AW'(1'b1);
    // One extra bit on each side: the MSB is the carry for ADD and the borrow for SUB.
    assign sum_s     = {1'b0, acca_r} + {1'b0, accb_r};
    assign diff_s    = {1'b0, acca_r} - {1'b0, accb_r};

    // Phase sequencer: next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.RUN) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH:     state_nxt_s = ST_DECODE;
            ST_DECODE:    state_nxt_s = ST_EXECUTE;
            ST_EXECUTE:   state_nxt_s = ST_WRITEBACK;
            ST_WRITEBACK: begin
                if (opcode_s == OP_HLT) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            default:      state_nxt_s = ST_IDLE;
        endcase
    end

    // Phase sequencer: state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // ALU and register-file results of the instruction in IR (committed at EXECUTE).
    always_comb begin
        acca_nxt_s      = acca_r;
        accb_nxt_s      = accb_r;
        zero_nxt_s      = zero_r;
        carry_nxt_s     = carry_r;
        out_data_nxt_s  = out_data_r;
        out_valid_nxt_s = 1'b0;
        case (opcode_s)
            OP_LDA:  acca_nxt_s = operand_s;
            OP_LDB:  accb_nxt_s = operand_s;
            OP_ADD: begin
                acca_nxt_s  = sum_s[DW-1:0];
                carry_nxt_s = sum_s[DW];
                zero_nxt_s  = (sum_s[DW-1:0] == {DW{1'b0}});
            end
            OP_SUB: begin
                acca_nxt_s  = diff_s[DW-1:0];
                carry_nxt_s = diff_s[DW];
                zero_nxt_s  = (diff_s[DW-1:0] == {DW{1'b0}});
            end
            OP_OUT: begin
                out_data_nxt_s  = acca_r;
                out_valid_nxt_s = 1'b1;
            end
            OP_MOVB: accb_nxt_s = acca_r;
            default: acca_nxt_s = acca_r;
        endcase
    end

    // Next program counter (committed at WRITEBACK); JZ sees flags already updated.
    always_comb begin
        pc_nxt_s = pc_inc_s;
        case (opcode_s)
            OP_JMP: pc_nxt_s = target_s;
            OP_JZ: begin
                if (zero_r) begin
                    pc_nxt_s = target_s;
                end else begin
                    pc_nxt_s = pc_inc_s;
                end
            end
            default: pc_nxt_s = pc_inc_s;
        endcase
    end

    // Architectural registers: each phase commits only its own slice of state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ir_r        <= {IW{1'b0}};
            pc_r        <= {AW{1'b0}};
            acca_r      <= {DW{1'b0}};
            accb_r      <= {DW{1'b0}};
            zero_r      <= 1'b0;
            carry_r     <= 1'b0;
            out_data_r  <= {DW{1'b0}};
            out_valid_r <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.RUN) begin
                        halted_r <= 1'b0;
                    end
                end
                ST_FETCH: ir_r <= mem_r[pc_r];
                ST_DECODE: ir_r <= ir_r;
                ST_EXECUTE: begin
                    acca_r      <= acca_nxt_s;
                    accb_r      <= accb_nxt_s;
                    zero_r      <= zero_nxt_s;
                    carry_r     <= carry_nxt_s;
                    out_data_r  <= out_data_nxt_s;
                    out_valid_r <= out_valid_nxt_s;
                end
                ST_WRITEBACK: begin
                    pc_r <= pc_nxt_s;
                    if (opcode_s == OP_HLT) begin
                        halted_r <= 1'b1;
                    end
                end
                default: ir_r <= ir_r;
            endcase
        end
    end

    // Program memory: reset never clears it; loads are accepted only while idle.
    always_ff @(posedge CLK) begin
        if (!RST && (state_r == ST_IDLE) && bus.PROG_WE) begin
            mem_r[bus.PROG_ADDR] <= bus.PROG_DATA;
        end
    end

    assign bus.PHASE     = state_r;
    assign bus.PC        = pc_r;
    assign bus.INSTR     = opcode_s;
    assign bus.ACCA      = acca_r;
    assign bus.ACCB      = accb_r;
    assign bus.ZERO      = zero_r;
    assign bus.CARRY     = carry_r;
    assign bus.OUT_DATA  = out_data_r;
    assign bus.OUT_VALID = out_valid_r;
    assign bus.HALTED    = halted_r;
endmodule

// File: tb/tb_vsmp_core_param.sv
// -----------------------------------------------------------------------------
// tb_vsmp_core_param
// Three core instances (DW/AW = 4/2, 4/3, 8/2) run side by side. A behavioural
// model per instance executes the instruction set phase by phase with plain
// integer arithmetic; every cycle all outputs of every instance are compared
// against it. Directed programs pin the model with hand-computed values, then
// randomized stimulus (program loads, RUN, stray writes, resets) follows.
// -----------------------------------------------------------------------------
module tb_vsmp_core_param;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance stimulus, driven only right after a falling edge.
    logic        rst_v  [NI];
    logic        run_v  [NI];
    logic        we_v   [NI];
    logic [31:0] addr_v [NI];
    logic [31:0] data_v [NI];

    // Per-instance outputs, zero-extended to 32 bits.
    logic [31:0] o_phase [NI], o_pc [NI], o_instr [NI], o_acca [NI], o_accb [NI];
    logic [31:0] o_zero [NI], o_carry [NI], o_od [NI], o_ov [NI], o_halt [NI];

    int dwv [NI] = '{4, 4, 8};
    int awv [NI] = '{2, 3, 2};

    vsmp_core_param_if #(.DW(4), .AW(2)) if0 ();
    vsmp_core_param_if #(.DW(4), .AW(3)) if1 ();
    vsmp_core_param_if #(.DW(8), .AW(2)) if2 ();

    vsmp_core_param #(.DW(4), .AW(2)) u0 (.CLK(clk), .RST(rst_v[0]), .bus(if0));
    vsmp_core_param #(.DW(4), .AW(3)) u1 (.CLK(clk), .RST(rst_v[1]), .bus(if1));
    vsmp_core_param #(.DW(8), .AW(2)) u2 (.CLK(clk), .RST(rst_v[2]), .bus(if2));

    assign if0.RUN = run_v[0]; assign if0.PROG_WE = we_v[0];
    assign if0.PROG_ADDR = addr_v[0][1:0]; assign if0.PROG_DATA = data_v[0][7:0];
    assign if1.RUN = run_v[1]; assign if1.PROG_WE = we_v[1];
    assign if1.PROG_ADDR = addr_v[1][2:0]; assign if1.PROG_DATA = data_v[1][7:0];
    assign if2.RUN = run_v[2]; assign if2.PROG_WE = we_v[2];
    assign if2.PROG_ADDR = addr_v[2][1:0]; assign if2.PROG_DATA = data_v[2][11:0];

    assign o_phase[0] = 32'(if0.PHASE); assign o_pc[0] = 32'(if0.PC); assign o_instr[0] = 32'(if0.INSTR);
    assign o_acca[0] = 32'(if0.ACCA); assign o_accb[0] = 32'(if0.ACCB); assign o_zero[0] = 32'(if0.ZERO);
    assign o_carry[0] = 32'(if0.CARRY); assign o_od[0] = 32'(if0.OUT_DATA);
    assign o_ov[0] = 32'(if0.OUT_VALID); assign o_halt[0] = 32'(if0.HALTED);
    assign o_phase[1] = 32'(if1.PHASE); assign o_pc[1] = 32'(if1.PC); assign o_instr[1] = 32'(if1.INSTR);
    assign o_acca[1] = 32'(if1.ACCA); assign o_accb[1] = 32'(if1.ACCB); assign o_zero[1] = 32'(if1.ZERO);
    assign o_carry[1] = 32'(if1.CARRY); assign o_od[1] = 32'(if1.OUT_DATA);
    assign o_ov[1] = 32'(if1.OUT_VALID); assign o_halt[1] = 32'(if1.HALTED);
    assign o_phase[2] = 32'(if2.PHASE); assign o_pc[2] = 32'(if2.PC); assign o_instr[2] = 32'(if2.INSTR);
    assign o_acca[2] = 32'(if2.ACCA); assign o_accb[2] = 32'(if2.ACCB); assign o_zero[2] = 32'(if2.ZERO);
    assign o_carry[2] = 32'(if2.CARRY); assign o_od[2] = 32'(if2.OUT_DATA);
    assign o_ov[2] = 32'(if2.OUT_VALID); assign o_halt[2] = 32'(if2.HALTED);

    // ---------------- behavioural model ----------------
    // m_ph: 0 idle, 1 fetch, 2 decode, 3 execute, 4 writeback
    int m_ph [NI], m_pc [NI], m_ir [NI], m_a [NI], m_b [NI];
    int m_z [NI], m_c [NI], m_od [NI], m_ov [NI], m_h [NI];
    int m_mem [NI][8];
    bit m_valid [NI];

    int n_checks = 0;
    int n_errors = 0;

    task automatic model_step(input int k);
        int dm, am, op, kk, r;
        dm = (1 << dwv[k]) - 1;
        am = (1 << awv[k]) - 1;
        if (rst_v[k]) begin
            m_ph[k] = 0; m_pc[k] = 0; m_ir[k] = 0; m_a[k] = 0; m_b[k] = 0;
            m_z[k] = 0; m_c[k] = 0; m_od[k] = 0; m_ov[k] = 0; m_h[k] = 0;
            m_valid[k] = 1'b1;
            return;
        end
        if (!m_valid[k]) return;
        op = (m_ir[k] >> dwv[k]) & 15;
        kk = m_ir[k] & dm;
        m_ov[k] = 0;
        case (m_ph[k])
            0: begin
                if (we_v[k]) m_mem[k][addr_v[k] & am] = data_v[k] & ((1 << (dwv[k] + 4)) - 1);
                if (run_v[k]) begin m_ph[k] = 1; m_h[k] = 0; end
            end
            1: begin m_ir[k] = m_mem[k][m_pc[k]]; m_ph[k] = 2; end
            2: m_ph[k] = 3;
            3: begin
                case (op)
                    1: m_a[k] = kk;
                    2: m_b[k] = kk;
                    3: begin
                        r = m_a[k] + m_b[k];
                        m_c[k] = (r > dm) ? 1 : 0;
                        m_a[k] = r & dm;
                        m_z[k] = (m_a[k] == 0) ? 1 : 0;
                    end
                    4: begin
                        m_c[k] = (m_a[k] < m_b[k]) ? 1 : 0;
                        m_a[k] = (m_a[k] - m_b[k]) & dm;
                        m_z[k] = (m_a[k] == 0) ? 1 : 0;
                    end
                    5: begin m_od[k] = m_a[k]; m_ov[k] = 1; end
                    8: m_b[k] = m_a[k];
                    default: ;
                endcase
                m_ph[k] = 4;
            end
            4: begin
                if (op == 6) m_pc[k] = kk & am;
                else if (op == 7 && m_z[k] == 1) m_pc[k] = kk & am;
                else m_pc[k] = (m_pc[k] + 1) & am;
                if (op == 15) begin m_h[k] = 1; m_ph[k] = 0; end
                else m_ph[k] = 1;
            end
            default: m_ph[k] = 0;
        endcase
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) model_step(k);
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s u%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic compare_inst(input int k);
        int ph_exp;
        if (!m_valid[k]) return;
        ph_exp = (m_ph[k] == 0) ? 0 : (1 << (m_ph[k] - 1));
        chk("PHASE", k, o_phase[k], ph_exp);
        chk("PC", k, o_pc[k], m_pc[k]);
        chk("INSTR", k, o_instr[k], (m_ir[k] >> dwv[k]) & 15);
        chk("ACCA", k, o_acca[k], m_a[k]);
        chk("ACCB", k, o_accb[k], m_b[k]);
        chk("ZERO", k, o_zero[k], m_z[k]);
        chk("CARRY", k, o_carry[k], m_c[k]);
        chk("OUT_DATA", k, o_od[k], m_od[k]);
        chk("OUT_VALID", k, o_ov[k], m_ov[k]);
        chk("HALTED", k, o_halt[k], m_h[k]);
    endtask

    // One clock: wait for the falling edge, then compare every instance to its model.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < NI; k++) compare_inst(k);
    endtask

    function automatic int enc(input int k, input int op, input int kk);
        return (op << dwv[k]) | kk;
    endfunction

    task automatic load_prog(input int k, input int p [8]);
        for (int i = 0; i < (1 << awv[k]); i++) begin
            we_v[k] = 1'b1; addr_v[k] = i; data_v[k] = p[i];
            tick();
        end
        we_v[k] = 1'b0;
    endtask

    task automatic pulse_run(input int k);
        run_v[k] = 1'b1;
        tick();
        run_v[k] = 1'b0;
    endtask

    int p [8];
    int ov_cnt, ov_cyc, subs, op, dm;

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst_v[k] = 1'b1; run_v[k] = 1'b0; we_v[k] = 1'b0; addr_v[k] = 0; data_v[k] = 0;
            m_valid[k] = 1'b0;
            for (int i = 0; i < 8; i++) m_mem[k][i] = 0;
        end
        tick();
        tick();
        for (int k = 0; k < NI; k++) rst_v[k] = 1'b0;
        chk("reset PHASE", 0, o_phase[0], 32'd0);
        chk("reset HALTED", 0, o_halt[0], 32'd0);

        // ADD then HLT: PC wraps 3 -> 0
        p = '{enc(0, 1, 5), enc(0, 2, 3), enc(0, 3, 0), enc(0, 15, 0), 0, 0, 0, 0};
        load_prog(0, p);
        pulse_run(0);
        repeat (16) tick();
        chk("t1 ACCA", 0, o_acca[0], 32'h8);
        chk("t1 CARRY", 0, o_carry[0], 32'd0);
        chk("t1 ZERO", 0, o_zero[0], 32'd0);
        chk("t1 HALTED", 0, o_halt[0], 32'd1);
        chk("t1 PC", 0, o_pc[0], 32'd0);
        chk("t1 PHASE", 0, o_phase[0], 32'd0);

        // Write while running is ignored: HLT at address 3 survives
        pulse_run(0);
        we_v[0] = 1'b1; addr_v[0] = 3; data_v[0] = enc(0, 1, 10);
        tick();
        we_v[0] = 1'b0;
        repeat (15) tick();
        chk("t4 busy-write ACCA", 0, o_acca[0], 32'h8);
        chk("t4 busy-write HALTED", 0, o_halt[0], 32'd1);

        // Write in IDLE together with RUN: next FETCH sees the new word
        we_v[0] = 1'b1; addr_v[0] = 0; data_v[0] = enc(0, 1, 10); run_v[0] = 1'b1;
        tick();
        we_v[0] = 1'b0; run_v[0] = 1'b0;
        repeat (3) tick();
        chk("t4 idle-write INSTR", 0, o_instr[0], 32'd1);
        chk("t4 idle-write ACCA", 0, o_acca[0], 32'hA);
        repeat (13) tick();
        chk("t4 rerun ACCA", 0, o_acca[0], 32'hD);
        chk("t4 rerun HALTED", 0, o_halt[0], 32'd1);

        // Reset during EXECUTE of ADD
        pulse_run(0);
        repeat (10) tick();
        chk("t5 in EXECUTE", 0, o_phase[0], 32'h4);
        chk("t5 ADD in IR", 0, o_instr[0], 32'h3);
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        chk("t5 PHASE", 0, o_phase[0], 32'd0);
        chk("t5 ACCA", 0, o_acca[0], 32'd0);
        chk("t5 PC", 0, o_pc[0], 32'd0);
        chk("t5 ZERO", 0, o_zero[0], 32'd0);
        chk("t5 CARRY", 0, o_carry[0], 32'd0);
        pulse_run(0);
        repeat (16) tick();
        chk("t5 rerun ACCA", 0, o_acca[0], 32'hD);
        chk("t5 rerun HALTED", 0, o_halt[0], 32'd1);

        // SUB with borrow then OUT: single OUT_VALID pulse at cycle 16
        p = '{enc(0, 1, 2), enc(0, 2, 3), enc(0, 4, 0), enc(0, 5, 0), 0, 0, 0, 0};
        load_prog(0, p);
        pulse_run(0);
        ov_cnt = 0; ov_cyc = -1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (o_ov[0] == 32'd1) begin ov_cnt++; ov_cyc = i + 1; end
        end
        chk("t2 OUT_VALID pulses", 0, ov_cnt, 32'd1);
        chk("t2 OUT_VALID cycle", 0, ov_cyc, 32'd16);
        chk("t2 ACCA", 0, o_acca[0], 32'hF);
        chk("t2 CARRY", 0, o_carry[0], 32'd1);
        chk("t2 OUT_DATA", 0, o_od[0], 32'hF);
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;

        // Countdown loop, AW=3
        p = '{enc(1, 1, 3), enc(1, 2, 1), enc(1, 4, 0), enc(1, 7, 5), enc(1, 6, 2), enc(1, 15, 0), 0, 0};
        load_prog(1, p);
        pulse_run(1);
        subs = 0;
        for (int i = 0; i < 300 && o_halt[1] == 32'd0; i++) begin
            tick();
            if (o_phase[1] == 32'h8 && o_instr[1] == 32'h4) subs++;
        end
        chk("t3 SUB count", 1, subs, 32'd3);
        chk("t3 ACCA", 1, o_acca[1], 32'd0);
        chk("t3 ZERO", 1, o_zero[1], 32'd1);
        chk("t3 HALTED", 1, o_halt[1], 32'd1);
        chk("t3 PC", 1, o_pc[1], 32'd6);

        // DW=8 overflow
        p = '{enc(2, 1, 255), enc(2, 2, 1), enc(2, 3, 0), enc(2, 15, 0), 0, 0, 0, 0};
        load_prog(2, p);
        pulse_run(2);
        repeat (16) tick();
        chk("t6 ACCA", 2, o_acca[2], 32'h00);
        chk("t6 CARRY", 2, o_carry[2], 32'd1);
        chk("t6 ZERO", 2, o_zero[2], 32'd1);
        chk("t6 HALTED", 2, o_halt[2], 32'd1);

        // Randomized traffic on all instances, checked every cycle against the model
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NI; k++) begin
                dm = (1 << dwv[k]) - 1;
                op = $urandom_range(0, 11);
                if (op == 9) op = 15;
                else if (op > 9) op = $urandom_range(0, 15);
                rst_v[k]  = ($urandom_range(0, 199) == 0);
                run_v[k]  = ($urandom_range(0, 7) == 0);
                we_v[k]   = ($urandom_range(0, 3) == 0);
                addr_v[k] = $urandom_range(0, (1 << awv[k]) - 1);
                data_v[k] = (op << dwv[k]) | ($urandom & dm);
            end
            tick();
        end
        for (int k = 0; k < NI; k++) begin
            rst_v[k] = 1'b0; run_v[k] = 1'b0; we_v[k] = 1'b0;
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
